camera_frame_tx: RTL

Camera-side transmitter for the pixel interface consumed by the ML harvest-detection path. It generates RGB332 frames with `vsync`/`href` framing, one pixel per enabled clock. It sits in front of the ML receiver as an on-chip test-pattern source and bring-up stimulus. It can also serve as the golden producer in system benches, with optional pixel-class statistics for cross-checking the receiver's green/red counts.

---
 rtl/camera_frame_tx_pkg.sv | 50 +++++
 rtl/camera_frame_tx_pattern.sv | 49 ++++
 rtl/camera_frame_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/camera_frame_tx_pkg.sv
// camera_frame_tx shared types and constants.
// FSM states, pattern codes, colours, LFSR and pixel classifier.
package camera_frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_LINE,
    S_HBLANK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_GREEN,
    CLS_RED
  } pix_class_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_HALF  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] RED   = 8'hE0;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    lfsr_next = {1'b0, s[7:1]}
              ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic pix_class_t classify(
    input logic [7:0] p
  );
    pix_class_t c;
    c = CLS_NONE;
    if (p[4:2] > 3'b100 && p[7:5] < 3'b011)
      c = CLS_GREEN;
    else if (p[7:5] > 3'b100)
      c = CLS_RED;
    return c;
  endfunction

endpackage

// File: rtl/camera_frame_tx_pattern.sv
// frame_pattern_gen: pixel value for the current raster position.
// Owns the LFSR used by the pseudo-random pattern.
module frame_pattern_gen
  import camera_frame_tx_pkg::*;
#(
  parameter int H_ACTIVE = 16,
  parameter int X_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [X_W-1:0] x,
  input  logic           y,
  input  logic [1:0]     pattern,
  input  logic [7:0]     color,
  input  logic           advance,
  input  logic           reseed,
  output logic [7:0]     pixel
);

  logic [7:0] lfsr;

  // LFSR restarts each frame and steps once per emitted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (ena) begin
      if (reseed)
        lfsr <= LFSR_SEED;
      else if (advance)
        lfsr <= lfsr_next(lfsr);
    end
  end

  // Pattern decode; y is only the line parity
  always_comb begin
    pixel = color;
    unique case (pattern)
      PAT_SOLID: pixel = color;
      PAT_HALF:
        pixel = (x < X_W'(H_ACTIVE / 2))
              ? GREEN : RED;
      PAT_CHECK:
        pixel = (x[0] ^ y) ? RED : GREEN;
      default: pixel = lfsr;
    endcase
  end

endmodule

// File: rtl/camera_frame_tx.sv
// camera_frame_tx: RGB332 test-frame source with vsync/href framing.
// Optional class statistics under CAMERA_FRAME_TX_STATS_EN.
module camera_frame_tx
  import camera_frame_tx_pkg::*;
#(
  parameter int H_ACTIVE  = 16,
  parameter int V_ACTIVE  = 8,
  parameter int H_BLANK   = 4,
  parameter int VSYNC_LEN = 2,
  parameter int V_BACK    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  color_in,
  output logic [7:0]  pixel,
  output logic        vsync,
  output logic        href,
  output logic        busy,
  output logic        frame_done,
  output logic [11:0] green_cnt,
  output logic [11:0] red_cnt
);

  localparam int X_W = $clog2(H_ACTIVE);
  localparam int Y_W =
    (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int C_M1 =
    (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int C_MAX =
    (C_M1 > H_BLANK) ? C_M1 : H_BLANK;
  localparam int C_W =
    (C_MAX > 1) ? $clog2(C_MAX) : 1;

  state_t         state, state_n;
  logic [C_W-1:0] cnt, cnt_n;
  logic [X_W-1:0] x, x_n;
  logic [Y_W-1:0] y, y_n;
  logic [1:0]     pat_q;
  logic [7:0]     col_q;
  logic [7:0]     pat_pixel;
  logic           accept;
  logic           in_line;

  assign in_line = (state_n == S_LINE);

  // Next-state and raster counter sequencing
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    y_n     = y;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_VSYNC;
          cnt_n   = '0;
          x_n     = '0;
          y_n     = '0;
        end
      end
      S_VSYNC: begin
        if (cnt == C_W'(VSYNC_LEN - 1)) begin
          state_n = S_VBACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + C_W'(1);
        end
      end
      S_VBACK: begin
        if (cnt == C_W'(V_BACK - 1)) begin
          state_n = S_LINE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + C_W'(1);
        end
      end
      S_LINE: begin
        if (x == X_W'(H_ACTIVE - 1)) begin
          state_n = S_HBLANK;
          cnt_n   = '0;
        end else begin
          x_n = x + X_W'(1);
        end
      end
      S_HBLANK: begin
        if (cnt == C_W'(H_BLANK - 1)) begin
          cnt_n = '0;
          if (y < Y_W'(V_ACTIVE - 1)) begin
            state_n = S_LINE;
            y_n     = y + Y_W'(1);
            x_n     = '0;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          cnt_n = cnt + C_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  frame_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .X_W      (X_W)
  ) u_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .x       (x_n),
    .y       (y_n[0]),
    .pattern (pat_q),
    .color   (col_q),
    .advance (in_line),
    .reseed  (accept),
    .pixel   (pat_pixel)
  );

  // State, latched config and outputs registered from next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      pat_q      <= '0;
      col_q      <= '0;
      pixel      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      y     <= y_n;
      if (accept) begin
        pat_q <= pattern_sel;
        col_q <= color_in;
      end
      pixel      <= in_line ? pat_pixel : 8'h00;
      vsync      <= (state_n == S_VSYNC);
      href       <= in_line;
      busy       <= (state_n != S_IDLE);
      frame_done <= (state_n == S_DONE);
    end
  end

`ifdef CAMERA_FRAME_TX_STATS_EN
  logic [11:0] g_acc, r_acc;
  pix_class_t  cls;

  assign cls = classify(pat_pixel);

  // Saturating per-frame tallies, published on DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_acc     <= '0;
      r_acc     <= '0;
      green_cnt <= '0;
      red_cnt   <= '0;
    end else if (ena) begin
      if (accept) begin
        g_acc <= '0;
        r_acc <= '0;
      end else if (in_line) begin
        if (cls == CLS_GREEN && g_acc != 12'hFFF)
          g_acc <= g_acc + 12'd1;
        if (cls == CLS_RED && r_acc != 12'hFFF)
          r_acc <= r_acc + 12'd1;
      end
      if (state_n == S_DONE) begin
        green_cnt <= g_acc;
        red_cnt   <= r_acc;
      end
    end
  end
`else
  assign green_cnt = 12'd0;
  assign red_cnt   = 12'd0;
`endif

endmodule
